// File: rtl/sparc_ifu_imenc_if.sv
// Request / instruction-word channel bundle for sparc_ifu_imenc.
//  master : request producer and instruction-word consumer (injector side)
//  slave  : the encoder itself
interface sparc_ifu_imenc_if;

    // Field-level encode request
    logic        req_vld;
    logic        req_rdy;
    logic [2:0]  req_fmt;
    logic [5:0]  req_op3;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [3:0]  req_cond;
    logic        req_abit;
    logic [31:0] req_imm;

    // Encoded instruction word towards the S-stage injection path
    logic        inst_vld;
    logic        inst_rdy;
    logic [31:0] inst_word;

    modport master (
        output req_vld, req_fmt, req_op3, req_rd, req_rs1, req_cond, req_abit, req_imm,
        input  req_rdy,
        input  inst_vld, inst_word,
        output inst_rdy
    );

    modport slave (
        input  req_vld, req_fmt, req_op3, req_rd, req_rs1, req_cond, req_abit, req_imm,
        output req_rdy,
        output inst_vld, inst_word,
        input  inst_rdy
    );

endinterface

// File: rtl/sparc_ifu_imenc.sv
// sparc_ifu_imenc: packs field-level requests into 32b SPARC V9 instruction
// words and queues them in a small FIFO for the IFU test/patch injector.
// Optional feature macro: SPARC_IFU_IMENC_RANGECHK_EN
//   defined   -> requests whose immediate is not exactly representable are
//                dropped, flagged on enc_err and counted in err_cnt
//   undefined -> fields are silently truncated, enc_err/err_cnt tied to 0
module sparc_ifu_imenc #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = 8
) (
    input  logic            rclk,
    input  logic            arst_l,
    input  logic            flush,
    sparc_ifu_imenc_if.slave bus,
    output logic            enc_err,
    output logic [CNTW-1:0] err_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          rdy_en;

    logic [31:0]   enc_word;
    logic          enc_bad;
    logic          accept;
    logic          push;
    logic          pop;

    // Handshake qualifiers; no bypass, so a full FIFO is never ready
    assign bus.req_rdy   = rdy_en & (count < CW'(DEPTH)) & ~flush;
    assign accept        = bus.req_vld & bus.req_rdy;
    assign push          = accept & ~enc_bad;
    assign bus.inst_vld  = (count != '0);
    assign pop           = bus.inst_vld & bus.inst_rdy;
    // Head word is masked to zero when empty so nothing stale ever shows
    assign bus.inst_word = bus.inst_vld ? mem[rd_ptr] : '0;

    // Field packing for all eight supported formats
    always_comb begin
        enc_word = '0;
        case (bus.req_fmt)
            3'd0: enc_word = {2'b10, bus.req_rd, bus.req_op3, bus.req_rs1, 1'b1,
                              bus.req_imm[12:0]};
            3'd1: enc_word = {2'b00, bus.req_rd, 3'b100, bus.req_imm[31:10]};
            3'd2: enc_word = {2'b00, bus.req_abit, bus.req_cond, 3'b010,
                              bus.req_imm[23:2]};
            3'd3: enc_word = {2'b00, bus.req_abit, bus.req_cond, 3'b001,
                              bus.req_rs1[1:0], bus.req_rs1[2], bus.req_imm[20:2]};
            3'd4: enc_word = {2'b00, bus.req_abit, 1'b0, bus.req_cond[2:0], 3'b011,
                              bus.req_imm[17:16], bus.req_cond[3], bus.req_rs1,
                              bus.req_imm[15:2]};
            3'd5: enc_word = {2'b01, bus.req_imm[31:2]};
            3'd6: enc_word = {2'b10, bus.req_rd, bus.req_op3, bus.req_rs1[2],
                              bus.req_cond, 1'b1, bus.req_rs1[1:0], bus.req_imm[10:0]};
            3'd7: enc_word = {2'b10, bus.req_rd, bus.req_op3, bus.req_rs1, 1'b1,
                              bus.req_cond[2:0], bus.req_imm[9:0]};
        endcase
    end

`ifdef SPARC_IFU_IMENC_RANGECHK_EN
    // True when v[31:lo] are all equal, i.e. v fits a (lo+1)-bit signed field
    function automatic logic uniform(input logic [31:0] v, input int unsigned lo);
        logic [31:0] sh;
        sh = 32'($signed(v) >>> lo);
        return (&sh) | ~(|sh);
    endfunction

    // Representability check of the immediate for the selected format
    always_comb begin
        enc_bad = 1'b0;
        case (bus.req_fmt)
            3'd0: enc_bad = ~uniform(bus.req_imm, 12);
            3'd1: enc_bad = |bus.req_imm[9:0];
            3'd2: enc_bad = (|bus.req_imm[1:0]) | ~uniform(bus.req_imm, 23);
            3'd3: enc_bad = (|bus.req_imm[1:0]) | ~uniform(bus.req_imm, 20);
            3'd4: enc_bad = (|bus.req_imm[1:0]) | ~uniform(bus.req_imm, 17);
            3'd5: enc_bad = |bus.req_imm[1:0];
            3'd6: enc_bad = ~uniform(bus.req_imm, 10);
            3'd7: enc_bad = ~uniform(bus.req_imm, 9);
        endcase
    end

    // Reject pulse and saturating reject counter; flush leaves the count alone
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            enc_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            enc_err <= accept & enc_bad;
            if (accept & enc_bad & ~(&err_cnt)) begin
                err_cnt <= err_cnt + CNTW'(1);
            end
        end
    end
`else
    assign enc_bad = 1'b0;
    assign enc_err = 1'b0;
    assign err_cnt = '0;
`endif

    // FIFO pointers and occupancy; flush wins over concurrent push/pop
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage array; contents need no reset since reads are gated by count
    always_ff @(posedge rclk) begin
        if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

endmodule

// File: tb/tb_sparc_ifu_imenc.sv
// Randomised self-checking bench for sparc_ifu_imenc with a queue-based
// reference model and a few literal encodings pinned by hand.
module tb_sparc_ifu_imenc;

    localparam int DEPTH = 4;
    localparam int CNTW  = 8;
`ifdef SPARC_IFU_IMENC_RANGECHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic            rclk   = 1'b0;
    logic            arst_l = 1'b0;
    logic            flush  = 1'b0;
    logic            enc_err;
    logic [CNTW-1:0] err_cnt;

    sparc_ifu_imenc_if bus();

    sparc_ifu_imenc #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .rclk    (rclk),
        .arst_l  (arst_l),
        .flush   (flush),
        .bus     (bus),
        .enc_err (enc_err),
        .err_cnt (err_cnt)
    );

    always #5 rclk = ~rclk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_q[$];
    bit          m_rdy_en = 1'b0;
    bit          m_err    = 1'b0;
    int          m_cnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word layout by field positions
    function automatic logic [31:0] m_enc(input int fmt, input logic [31:0] rd,
                                          input logic [31:0] op3, input logic [31:0] rs1,
                                          input logic [31:0] cond, input logic [31:0] a,
                                          input logic [31:0] imm);
        case (fmt)
            0: return (32'd2 << 30) | (rd << 25) | (op3 << 19) | (rs1 << 14) | (32'd1 << 13)
                      | (imm & 32'h1FFF);
            1: return (rd << 25) | (32'd4 << 22) | (imm >> 10);
            2: return (a << 29) | (cond << 25) | (32'd2 << 22) | ((imm >> 2) & 32'h3FFFFF);
            3: return (a << 29) | (cond << 25) | (32'd1 << 22) | ((rs1 & 3) << 20)
                      | (((rs1 >> 2) & 1) << 19) | ((imm >> 2) & 32'h7FFFF);
            4: return (a << 29) | ((cond & 7) << 25) | (32'd3 << 22) | (((imm >> 16) & 3) << 20)
                      | (((cond >> 3) & 1) << 19) | (rs1 << 14) | ((imm >> 2) & 32'h3FFF);
            5: return (32'd1 << 30) | (imm >> 2);
            6: return (32'd2 << 30) | (rd << 25) | (op3 << 19) | (((rs1 >> 2) & 1) << 18)
                      | (cond << 14) | (32'd1 << 13) | ((rs1 & 3) << 11) | (imm & 32'h7FF);
            default: return (32'd2 << 30) | (rd << 25) | (op3 << 19) | (rs1 << 14) | (32'd1 << 13)
                      | ((cond & 7) << 10) | (imm & 32'h3FF);
        endcase
    endfunction

    // Representability rules as signed-range arithmetic
    function automatic bit m_bad(input int fmt, input logic [31:0] imm);
        int s;
        bit mis;
        s   = $signed(imm);
        mis = (imm % 4) != 0;
        case (fmt)
            0: return s < -4096 || s > 4095;
            1: return (imm % 1024) != 0;
            2: return mis || s < -(1 << 23) || s > (1 << 23) - 1;
            3: return mis || s < -(1 << 20) || s > (1 << 20) - 1;
            4: return mis || s < -(1 << 17) || s > (1 << 17) - 1;
            5: return mis;
            6: return s < -1024 || s > 1023;
            default: return s < -512 || s > 511;
        endcase
    endfunction

    // Model update on every active edge and on asynchronous reset
    initial begin
        bit rdy, acc, pp, rej;
        forever begin
            @(posedge rclk or negedge arst_l);
            if (!arst_l) begin
                m_q.delete();
                m_rdy_en = 1'b0;
                m_err    = 1'b0;
                m_cnt    = 0;
            end else begin
                rdy = m_rdy_en && (m_q.size() < DEPTH) && !flush;
                acc = bus.req_vld && rdy;
                pp  = (m_q.size() > 0) && bus.inst_rdy;
                rej = CHK && acc && m_bad(int'(bus.req_fmt), bus.req_imm);
                if (flush) begin
                    m_q.delete();
                    m_err = 1'b0;
                end else begin
                    if (pp) void'(m_q.pop_front());
                    if (acc && !rej)
                        m_q.push_back(m_enc(int'(bus.req_fmt), 32'(bus.req_rd), 32'(bus.req_op3),
                                            32'(bus.req_rs1), 32'(bus.req_cond),
                                            32'(bus.req_abit), bus.req_imm));
                    m_err = rej;
                    if (rej && m_cnt < (1 << CNTW) - 1) m_cnt++;
                end
                m_rdy_en = 1'b1;
            end
        end
    end

    // Compare process: every falling edge
    initial begin
        forever begin
            @(negedge rclk);
            chk("req_rdy", 32'(bus.req_rdy),
                32'(m_rdy_en && (m_q.size() < DEPTH) && !flush));
            chk("inst_vld", 32'(bus.inst_vld), 32'(m_q.size() > 0));
            if (m_q.size() > 0) chk("inst_word", bus.inst_word, m_q[0]);
            chk("enc_err", 32'(enc_err), 32'(m_err));
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
        end
    end

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic set_req(input int fmt, input int rd, input int op3, input int rs1,
                           input int cond, input int a, input logic [31:0] imm);
        bus.req_vld  = 1'b1;
        bus.req_fmt  = 3'(fmt);
        bus.req_rd   = 5'(rd);
        bus.req_op3  = 6'(op3);
        bus.req_rs1  = 5'(rs1);
        bus.req_cond = 4'(cond);
        bus.req_abit = 1'(a);
        bus.req_imm  = imm;
    endtask

    function automatic logic [31:0] rnd_imm();
        case ($urandom % 4)
            0: return $urandom;
            1: return 32'(int'($urandom_range(0, 2047)) - 1024);
            2: return 32'(int'($urandom_range(0, 1 << 19)) - (1 << 18)) & 32'hFFFFFFFC;
            default: return $urandom & 32'hFFFFFC00;
        endcase
    endfunction

    task automatic rnd_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom % 4 != 0)
                set_req(int'($urandom % 8), int'($urandom % 32), int'($urandom % 64),
                        int'($urandom % 32), int'($urandom % 16), int'($urandom % 2), rnd_imm());
            else
                bus.req_vld = 1'b0;
            bus.inst_rdy = ($urandom % 3) != 0;
            flush        = ($urandom % 50) == 0;
            step();
        end
        bus.req_vld = 1'b0;
        flush       = 1'b0;
    endtask

    initial begin
        set_req(0, 0, 0, 0, 0, 0, 32'h0);
        bus.req_vld  = 1'b0;
        bus.inst_rdy = 1'b0;

        // Reset state
        #12;
        chk("rst_inst_vld", 32'(bus.inst_vld), 32'h0);
        chk("rst_inst_word", bus.inst_word, 32'h0);
        chk("rst_req_rdy", 32'(bus.req_rdy), 32'h0);
        #10 arst_l = 1'b1;
        #1;
        chk("rdy_before_edge", 32'(bus.req_rdy), 32'h0);
        @(negedge rclk);
        chk("rdy_after_edge", 32'(bus.req_rdy), 32'h1);

        // Pinned encodings
        step();
        set_req(0, 3, 0, 1, 0, 0, 32'hFFFFFFFF);
        step();
        bus.req_vld = 1'b0;
        @(negedge rclk);
        chk("fmt0_vld", 32'(bus.inst_vld), 32'h1);
        chk("fmt0_word", bus.inst_word, 32'h86007FFF);
        step();
        bus.inst_rdy = 1'b1;
        set_req(5, 0, 0, 0, 0, 0, 32'h00000100);
        step();
        bus.req_vld = 1'b0;
        @(negedge rclk);
        chk("fmt5_word", bus.inst_word, 32'h40000040);
        step();
        set_req(1, 1, 0, 0, 0, 0, 32'h12345400);
        step();
        bus.req_vld = 1'b0;
        @(negedge rclk);
        chk("fmt1_word", bus.inst_word, 32'h03048D15);
        step();
        step();
        bus.inst_rdy = 1'b0;

        // Fill to DEPTH, then push+pop on a full FIFO, then drain (two rounds for wrap)
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                set_req(5, 0, 0, 0, 0, 0, 32'(i << 4));
                step();
            end
            bus.inst_rdy = 1'b1;
            @(negedge rclk);
            chk("full_rdy", 32'(bus.req_rdy), 32'h0);
            step();
            bus.req_vld = 1'b0;
            @(negedge rclk);
            chk("after_full_head", bus.inst_word, 32'h40000004);
            for (int i = 0; i < DEPTH; i++) step();
            bus.inst_rdy = 1'b0;
        end

        // Out-of-range fmt0 immediate
        set_req(0, 2, 5, 4, 0, 0, 32'd4096);
        step();
        bus.req_vld = 1'b0;
        @(negedge rclk);
        chk("oor_enc_err", 32'(enc_err), 32'(CHK));
        chk("oor_err_cnt", 32'(err_cnt), 32'(CHK));
        chk("oor_inst_vld", 32'(bus.inst_vld), 32'(!CHK));
        bus.inst_rdy = 1'b1;
        step();

        // Counter saturation
        set_req(0, 2, 5, 4, 0, 0, 32'd4096);
        for (int i = 0; i < (1 << CNTW) + 3; i++) step();
        bus.req_vld = 1'b0;
        step();
        step();
        @(negedge rclk);
        chk("sat_err_cnt", 32'(err_cnt), CHK ? 32'hFF : 32'h0);

        // Flush with three entries queued and a concurrent push/pop
        bus.inst_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(5, 0, 0, 0, 0, 0, 32'(i << 8));
            step();
        end
        flush        = 1'b1;
        bus.inst_rdy = 1'b1;
        @(negedge rclk);
        chk("flush_rdy", 32'(bus.req_rdy), 32'h0);
        step();
        flush        = 1'b0;
        bus.req_vld  = 1'b0;
        bus.inst_rdy = 1'b0;
        @(negedge rclk);
        chk("flush_vld", 32'(bus.inst_vld), 32'h0);
        chk("flush_keeps_cnt", 32'(err_cnt), CHK ? 32'hFF : 32'h0);

        // Randomised traffic
        step();
        rnd_cycles(3000);

        // Asynchronous reset mid-burst
        bus.inst_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(5, 0, 0, 0, 0, 0, 32'(i << 12));
            step();
        end
        #2 arst_l = 1'b0;
        #1;
        chk("async_inst_vld", 32'(bus.inst_vld), 32'h0);
        chk("async_inst_word", bus.inst_word, 32'h0);
        chk("async_req_rdy", 32'(bus.req_rdy), 32'h0);
        chk("async_enc_err", 32'(enc_err), 32'h0);
        chk("async_err_cnt", 32'(err_cnt), 32'h0);
        bus.req_vld = 1'b0;
        step();
        step();
        #2 arst_l = 1'b1;
        step();
        step();
        chk("post_rst_vld", 32'(bus.inst_vld), 32'h0);
        chk("post_rst_word", bus.inst_word, 32'h0);

        rnd_cycles(500);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
